ram_arbiter: RTL

- Shares the single-port RAM command interface between two requesters (requester 0 = SPI slave path, requester 1 = on-chip test/debug master).
- Converts each high-level transaction (write addr+data, or read addr) into the RAM's 10-bit command sequence: 00 = write addr, 01 = write data, 10 = read addr, 11 = read.
- Returns read data and completion to the owning requester.

---
 rtl/ram_arbiter_pkg.sv | 23 ++
 rtl/ram_arbiter_if.sv | 47 ++++
 rtl/ram_arb_grant.sv | 52 +++++
 rtl/ram_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the two-requester RAM command arbiter.
package ram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    W_ADDR = 3'd1,
    W_DATA = 3'd2,
    R_ADDR = 3'd3,
    R_CMD  = 3'd4,
    R_WAIT = 3'd5,
    RESP   = 3'd6
  } arb_state_e;

  // RAM command opcodes carried in din[ADDR_SIZE+1:ADDR_SIZE]
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD      = 2'b11;

  // Requester index: 0 = SPI slave path, 1 = test/debug master
  typedef logic owner_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of requester handshakes, responses and the RAM command bus.
// master: requesters and RAM side; slave: the arbiter.
interface ram_arbiter_if #(
  parameter int ADDR_SIZE = 8
);
  logic                 req0_valid;
  logic                 req0_ready;
  logic                 req0_we;
  logic [ADDR_SIZE-1:0] req0_addr;
  logic [ADDR_SIZE-1:0] req0_wdata;
  logic                 rsp0_valid;
  logic [ADDR_SIZE-1:0] rsp0_rdata;
  logic                 rsp0_err;

  logic                 req1_valid;
  logic                 req1_ready;
  logic                 req1_we;
  logic [ADDR_SIZE-1:0] req1_addr;
  logic [ADDR_SIZE-1:0] req1_wdata;
  logic                 rsp1_valid;
  logic [ADDR_SIZE-1:0] rsp1_rdata;
  logic                 rsp1_err;

  logic [ADDR_SIZE+1:0] ram_din;
  logic                 ram_rx_valid;
  logic [ADDR_SIZE-1:0] ram_dout;
  logic                 ram_tx_valid;

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
    input  ram_din, ram_rx_valid,
    output ram_dout, ram_tx_valid
  );

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
    output ram_din, ram_rx_valid,
    input  ram_dout, ram_tx_valid
  );

endinterface

// File: rtl/ram_arb_grant.sv
// Grant selection between the two requesters.
// Fixed priority (requester 0 wins) by default; with ARB_ROUND_ROBIN_EN
// defined, a last-grant pointer makes ties alternate.
module ram_arb_grant
  import ram_arb_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
  input  logic   clk,
  input  logic   rst,
  input  logic   accept,
`endif
  input  logic   valid0,
  input  logic   valid1,
  output logic   gnt_any,
  output owner_t gnt_owner
);

`ifdef ARB_ROUND_ROBIN_EN
  owner_t last_q, last_d;

  // Tie goes to whoever was not granted last; a lone valid always wins
  always_comb begin
    gnt_any   = valid0 | valid1;
    gnt_owner = 1'b0;
    last_d    = last_q;
    if (valid0 && valid1) begin
      gnt_owner = ~last_q;
    end else begin
      gnt_owner = valid1;
    end
    if (accept) begin
      last_d = gnt_owner;
    end
  end

  // Pointer resets to 1 so requester 0 takes the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Requester 0 always wins a tie
  always_comb begin
    gnt_any   = valid0 | valid1;
    gnt_owner = ~valid0 & valid1;
  end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter for a single-port RAM command interface.
// Each accepted transaction becomes a two-command sequence on ram_din
// ({op, payload}); read data and a timeout flag return to the owner.
// Optional: define ARB_ROUND_ROBIN_EN for round-robin tie breaking.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_SIZE  = 8,
  parameter int RD_TIMEOUT = 4
) (
  input  logic         clk,
  input  logic         rst,
  ram_arbiter_if.slave bus
);

  localparam int               CNT_W    = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

  arb_state_e           state_q, state_d;
  owner_t               owner_q, owner_d;
  logic                 we_q, we_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [ADDR_SIZE-1:0] wdata_q, wdata_d;
  logic [ADDR_SIZE-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 rsp0_valid_q, rsp0_valid_d;
  logic [ADDR_SIZE-1:0] rsp0_rdata_q, rsp0_rdata_d;
  logic                 rsp0_err_q, rsp0_err_d;
  logic                 rsp1_valid_q, rsp1_valid_d;
  logic [ADDR_SIZE-1:0] rsp1_rdata_q, rsp1_rdata_d;
  logic                 rsp1_err_q, rsp1_err_d;

  logic                 gnt_any;
  owner_t               gnt_owner;
  logic                 accept;
  logic                 sel_we;
  logic [ADDR_SIZE-1:0] sel_addr;
  logic [ADDR_SIZE-1:0] sel_wdata;
  logic [ADDR_SIZE+1:0] ram_din_c;
  logic                 ram_rx_valid_c;

  ram_arb_grant u_grant (
`ifdef ARB_ROUND_ROBIN_EN
    .clk       (clk),
    .rst       (rst),
    .accept    (accept),
`endif
    .valid0    (bus.req0_valid),
    .valid1    (bus.req1_valid),
    .gnt_any   (gnt_any),
    .gnt_owner (gnt_owner)
  );

  // Only IDLE accepts; ready is held low while reset is applied
  assign accept         = (state_q == IDLE) && gnt_any && !rst;
  assign bus.req0_ready = accept && (gnt_owner == 1'b0);
  assign bus.req1_ready = accept && (gnt_owner == 1'b1);
  assign sel_we         = gnt_owner ? bus.req1_we    : bus.req0_we;
  assign sel_addr       = gnt_owner ? bus.req1_addr  : bus.req0_addr;
  assign sel_wdata      = gnt_owner ? bus.req1_wdata : bus.req0_wdata;

  // Transaction sequencing, field capture, read timeout and response staging
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d = gnt_owner;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          rdata_d = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = sel_we ? W_ADDR : R_ADDR;
        end
      end
      W_ADDR: state_d = W_DATA;
      W_DATA: state_d = RESP;
      R_ADDR: state_d = R_CMD;
      R_CMD:  state_d = R_WAIT;
      R_WAIT: begin
        if (bus.ram_tx_valid) begin
          rdata_d = bus.ram_dout;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Response is registered so it appears exactly while the FSM sits in RESP
    rsp0_valid_d = (state_d == RESP) && (owner_d == 1'b0);
    rsp1_valid_d = (state_d == RESP) && (owner_d == 1'b1);
    rsp0_rdata_d = rsp0_valid_d ? rdata_d : '0;
    rsp1_rdata_d = rsp1_valid_d ? rdata_d : '0;
    rsp0_err_d   = rsp0_valid_d & err_d;
    rsp1_err_d   = rsp1_valid_d & err_d;
  end

  // RAM command decode; din returns to 0 outside command states so the
  // RAM never sees a lingering read opcode
  always_comb begin
    ram_din_c      = '0;
    ram_rx_valid_c = 1'b0;
    unique case (state_q)
      W_ADDR: begin
        ram_din_c      = {CMD_WR_ADDR, addr_q};
        ram_rx_valid_c = 1'b1;
      end
      W_DATA: begin
        ram_din_c      = {CMD_WR_DATA, wdata_q};
        ram_rx_valid_c = 1'b1;
      end
      R_ADDR: begin
        ram_din_c      = {CMD_RD_ADDR, addr_q};
        ram_rx_valid_c = 1'b1;
      end
      R_CMD: begin
        ram_din_c      = {CMD_RD, {ADDR_SIZE{1'b0}}};
        ram_rx_valid_c = 1'b1;
      end
      default: begin
        ram_din_c      = '0;
        ram_rx_valid_c = 1'b0;
      end
    endcase
  end

  assign bus.ram_din      = ram_din_c;
  assign bus.ram_rx_valid = ram_rx_valid_c;
  assign bus.rsp0_valid   = rsp0_valid_q;
  assign bus.rsp0_rdata   = rsp0_rdata_q;
  assign bus.rsp0_err     = rsp0_err_q;
  assign bus.rsp1_valid   = rsp1_valid_q;
  assign bus.rsp1_rdata   = rsp1_rdata_q;
  assign bus.rsp1_err     = rsp1_err_q;

  // State and captured-field registers; reset drops any transaction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      rsp0_valid_q <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp0_err_q   <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp1_rdata_q <= '0;
      rsp1_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp0_err_q   <= rsp0_err_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp1_rdata_q <= rsp1_rdata_d;
      rsp1_err_q   <= rsp1_err_d;
    end
  end

endmodule
